// File: rtl/unidade_controle_partida.sv
`default_nettype none
// ============================================================================
// Module      : unidade_controle_partida
// Description : Game-flow controller for an N-player match. Sequences start,
//               seed capture, role reveal, night turns, timed day discussion,
//               voting, tally and game-over. Drives datapath enables and
//               tracks the current player, discussion timer and round count.
// Revision    : 1.0 - initial release
// ============================================================================
module unidade_controle_partida #(
    parameter int N_JOGADORES = 8,
    parameter int W_JOG       = 3,
    parameter int T_DISCUSSAO = 1000,
    parameter int W_TIMER     = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             jogar,
    input  logic             passa,
    input  logic             voto_valido,
    input  logic             fim_jogo,
    output logic             e_seed_reg,
    output logic             zera_CS,
    output logic             rst_global,
    output logic [W_JOG-1:0] jogador_atual,
    output logic             fase_noite,
    output logic             e_voto,
    output logic             timeout,
    output logic [7:0]       rodada,
    output logic [4:0]       db_estado
);

    // State codes double as the debug code presented on db_estado.
    typedef enum logic [3:0] {
        S_INICIAL       = 4'd0,
        S_RESETA_TUDO   = 4'd1,
        S_PREPARA_JOGO  = 4'd2,
        S_ARMAZENA_JOGO = 4'd3,
        S_REVELA        = 4'd4,
        S_PREPARA_NOITE = 4'd5,
        S_NOITE         = 4'd6,
        S_PREPARA_DIA   = 4'd7,
        S_DISCUSSAO     = 4'd8,
        S_VOTACAO       = 4'd9,
        S_APURA         = 4'd10,
        S_FIM           = 4'd11
    } estado_t;

    localparam logic [W_JOG-1:0]   C_ULTIMO_JOG = W_JOG'(N_JOGADORES - 1);
    localparam logic [W_JOG-1:0]   C_JOG_UM     = W_JOG'(1);
    localparam logic [W_TIMER-1:0] C_T_CARGA    = W_TIMER'(T_DISCUSSAO);
    localparam logic [W_TIMER-1:0] C_TIMER_UM   = W_TIMER'(1);
    localparam logic [7:0]         C_RODADA_MAX = 8'hFF;

    estado_t            state_q, state_d;
    logic [W_JOG-1:0]   idx_q, idx_d;
    logic [W_TIMER-1:0] timer_q, timer_d;
    logic [7:0]         rodada_q, rodada_d;

    logic e_seed_reg_q, e_seed_reg_d;
    logic zera_CS_q, zera_CS_d;
    logic rst_global_q, rst_global_d;
    logic fase_noite_q, fase_noite_d;
    logic e_voto_q, e_voto_d;
    logic timeout_q, timeout_d;

    logic w_ultimo;
    logic w_expira;

    assign w_ultimo = (idx_q == C_ULTIMO_JOG);
    // Expiry is the cycle the timer would tick from 1 to 0; a zero timer is
    // treated the same so a corrupted count can never stall the day phase.
    assign w_expira = (timer_q <= C_TIMER_UM);

    // Next-state, counter and output computation. Outputs are evaluated from
    // the next state so their registered copies line up with the state.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        timer_d  = timer_q;
        rodada_d = rodada_q;

        case (state_q)
            S_INICIAL: begin
                if (jogar) state_d = S_RESETA_TUDO;
            end
            S_RESETA_TUDO: begin
                idx_d    = '0;
                timer_d  = '0;
                rodada_d = '0;
                state_d  = S_PREPARA_JOGO;
            end
            S_PREPARA_JOGO: begin
                if (passa) state_d = S_ARMAZENA_JOGO;
            end
            S_ARMAZENA_JOGO: begin
                state_d = S_REVELA;
            end
            S_REVELA: begin
                if (passa) begin
                    if (w_ultimo) begin
                        idx_d   = '0;
                        state_d = S_PREPARA_NOITE;
                    end else begin
                        idx_d = idx_q + C_JOG_UM;
                    end
                end
            end
            S_PREPARA_NOITE: begin
                if (rodada_q != C_RODADA_MAX) rodada_d = rodada_q + 8'd1;
                state_d = S_NOITE;
            end
            S_NOITE: begin
                if (passa) begin
                    if (w_ultimo) begin
                        idx_d   = '0;
                        state_d = S_PREPARA_DIA;
                    end else begin
                        idx_d = idx_q + C_JOG_UM;
                    end
                end
            end
            S_PREPARA_DIA: begin
                if (fim_jogo) begin
                    state_d = S_FIM;
                end else begin
                    timer_d = C_T_CARGA;
                    state_d = S_DISCUSSAO;
                end
            end
            S_DISCUSSAO: begin
                if (timer_q != '0) timer_d = timer_q - C_TIMER_UM;
                // passa and expiry on the same cycle still give one entry.
                if (passa || w_expira) state_d = S_VOTACAO;
            end
            S_VOTACAO: begin
                if (voto_valido) begin
                    if (w_ultimo) begin
                        idx_d   = '0;
                        state_d = S_APURA;
                    end else begin
                        idx_d = idx_q + C_JOG_UM;
                    end
                end
            end
            S_APURA: begin
                state_d = fim_jogo ? S_FIM : S_PREPARA_NOITE;
            end
            S_FIM: begin
                if (jogar) state_d = S_RESETA_TUDO;
            end
            default: begin
                state_d = S_INICIAL;
            end
        endcase

        rst_global_d = (state_d == S_INICIAL) || (state_d == S_RESETA_TUDO);
        zera_CS_d    = (state_d == S_INICIAL) || (state_d == S_RESETA_TUDO);
        e_seed_reg_d = (state_d == S_ARMAZENA_JOGO);
        fase_noite_d = (state_d == S_NOITE);
        e_voto_d     = (state_d == S_VOTACAO);
        // High during the discussion cycle whose tick empties the timer.
        timeout_d    = (state_d == S_DISCUSSAO) && (timer_d == C_TIMER_UM);
    end

    // State, counters and registered outputs; reset parks the match in INICIAL.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_INICIAL;
            idx_q        <= '0;
            timer_q      <= '0;
            rodada_q     <= '0;
            rst_global_q <= 1'b1;
            zera_CS_q    <= 1'b1;
            e_seed_reg_q <= 1'b0;
            fase_noite_q <= 1'b0;
            e_voto_q     <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            timer_q      <= timer_d;
            rodada_q     <= rodada_d;
            rst_global_q <= rst_global_d;
            zera_CS_q    <= zera_CS_d;
            e_seed_reg_q <= e_seed_reg_d;
            fase_noite_q <= fase_noite_d;
            e_voto_q     <= e_voto_d;
            timeout_q    <= timeout_d;
        end
    end

    // Debug code straight from the state register; unused encodings flag 31.
    always_comb begin
        db_estado = 5'b11111;
        case (state_q)
            S_INICIAL, S_RESETA_TUDO, S_PREPARA_JOGO, S_ARMAZENA_JOGO,
            S_REVELA, S_PREPARA_NOITE, S_NOITE, S_PREPARA_DIA,
            S_DISCUSSAO, S_VOTACAO, S_APURA, S_FIM:
                db_estado = {1'b0, state_q};
            default:
                db_estado = 5'b11111;
        endcase
    end

    assign e_seed_reg    = e_seed_reg_q;
    assign zera_CS       = zera_CS_q;
    assign rst_global    = rst_global_q;
    assign jogador_atual = idx_q;
    assign fase_noite    = fase_noite_q;
    assign e_voto        = e_voto_q;
    assign timeout       = timeout_q;
    assign rodada        = rodada_q;

endmodule
`default_nettype wire

// File: tb/tb_unidade_controle_partida.sv
`default_nettype none
// ============================================================================
// Module      : tb_unidade_controle_partida
// Description : Randomised scoreboard bench for the match controller, with a
//               behavioural match model, async reset hits and a long run that
//               drives the round counter into saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_unidade_controle_partida;

    localparam int N = 4;
    localparam int T = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       jogar = 1'b0, passa = 1'b0, voto_valido = 1'b0, fim_jogo = 1'b0;
    logic       e_seed_reg, zera_CS, rst_global, fase_noite, e_voto, timeout;
    logic [2:0] jogador_atual;
    logic [7:0] rodada;
    logic [4:0] db_estado;

    unidade_controle_partida #(
        .N_JOGADORES(N), .W_JOG(3), .T_DISCUSSAO(T), .W_TIMER(3)
    ) dut (
        .clock(clk), .reset(reset), .jogar(jogar), .passa(passa),
        .voto_valido(voto_valido), .fim_jogo(fim_jogo),
        .e_seed_reg(e_seed_reg), .zera_CS(zera_CS), .rst_global(rst_global),
        .jogador_atual(jogador_atual), .fase_noite(fase_noite),
        .e_voto(e_voto), .timeout(timeout), .rodada(rodada),
        .db_estado(db_estado)
    );

    always #5 clk = ~clk;

    typedef struct {
        int fase; int jog; int rod;
        bit seed; bit zc; bit rg; bit noite; bit voto; bit to;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Behavioural match: phase number, whose turn it is, nights played and
    // how many discussion cycles have already elapsed.
    int m_fase = 0, m_jog = 0, m_rod = 0, m_gasto = 0;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic void proximo_jogador(input int fase_seguinte);
        if (m_jog == N - 1) begin
            m_jog  = 0;
            m_fase = fase_seguinte;
        end else begin
            m_jog = m_jog + 1;
        end
    endfunction

    function automatic void model_reset();
        m_fase = 0; m_jog = 0; m_rod = 0; m_gasto = 0;
    endfunction

    function automatic void model_step(input bit r, input bit j, input bit p,
                                       input bit v, input bit f);
        if (r) begin
            model_reset();
            return;
        end
        case (m_fase)
            0, 11: if (j) m_fase = 1;
            1: begin m_jog = 0; m_rod = 0; m_fase = 2; end
            2: if (p) m_fase = 3;
            3: m_fase = 4;
            4: if (p) proximo_jogador(5);
            5: begin m_rod = (m_rod < 255) ? m_rod + 1 : 255; m_fase = 6; end
            6: if (p) proximo_jogador(7);
            7: begin
                if (f) m_fase = 11;
                else begin m_gasto = 0; m_fase = 8; end
            end
            8: begin
                if (p || m_gasto == T - 1) m_fase = 9;
                else m_gasto = m_gasto + 1;
            end
            9: if (v) proximo_jogador(10);
            10: m_fase = f ? 11 : 5;
            default: m_fase = 0;
        endcase
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.fase  = m_fase;
        e.jog   = m_jog;
        e.rod   = m_rod;
        e.seed  = (m_fase == 3);
        e.zc    = (m_fase <= 1);
        e.rg    = (m_fase <= 1);
        e.noite = (m_fase == 6);
        e.voto  = (m_fase == 9);
        e.to    = (m_fase == 8) && (m_gasto == T - 1);
        return e;
    endfunction

    // Monitor: every settled cycle is compared against the queued prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("db_estado",     int'(db_estado),     e.fase);
                chk("jogador_atual", int'(jogador_atual), e.jog);
                chk("rodada",        int'(rodada),        e.rod);
                chk("e_seed_reg",    int'(e_seed_reg),    int'(e.seed));
                chk("zera_CS",       int'(zera_CS),       int'(e.zc));
                chk("rst_global",    int'(rst_global),    int'(e.rg));
                chk("fase_noite",    int'(fase_noite),    int'(e.noite));
                chk("e_voto",        int'(e_voto),        int'(e.voto));
                chk("timeout",       int'(timeout),       int'(e.to));
            end
        end
    end

    // One clock: advance the model with the inputs that were present at the
    // edge, optionally hit async reset mid-cycle, then queue the prediction.
    task automatic ciclo(input bit hit_reset);
        @(posedge clk);
        #1;
        model_step(reset, jogar, passa, voto_valido, fim_jogo);
        if (hit_reset) begin
            reset = 1'b1;
            #1;
            chk("reset_imediato_estado", int'(db_estado),     0);
            chk("reset_imediato_rg",     int'(rst_global),    1);
            chk("reset_imediato_jog",    int'(jogador_atual), 0);
            model_reset();
        end
        exp_q.push_back(model_out());
    endtask

    // Input odds lean on the model's phase so the match actually progresses.
    task automatic sorteia();
        jogar       = ($urandom_range(0, 99) < 40);
        voto_valido = ($urandom_range(0, 99) < 50);
        fim_jogo    = ($urandom_range(0, 99) < 15);
        if (m_fase == 8) passa = ($urandom_range(0, 99) < 15);
        else             passa = ($urandom_range(0, 99) < 50);
    endtask

    initial begin
        int resets_feitos;
        int ciclos;
        resets_feitos = 0;

        // Reset held for two edges, then the bench takes over.
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset_estado",  int'(db_estado),  0);
        chk("reset_rg",      int'(rst_global), 1);
        chk("reset_zc",      int'(zera_CS),    1);
        chk("reset_rodada",  int'(rodada),     0);
        model_reset();
        reset = 1'b0;
        sorteia();

        // Random matches with a few asynchronous resets during voting.
        for (int i = 0; i < 3000; i++) begin
            bit hit;
            hit = (m_fase == 9) && (resets_feitos < 3) && ($urandom_range(0, 9) == 0);
            ciclo(hit);
            if (hit) begin
                resets_feitos++;
                ciclo(1'b0);
                reset = 1'b0;
            end
            sorteia();
        end

        // Fast-forward through many rounds to saturate the round counter.
        jogar = 1'b1; passa = 1'b1; voto_valido = 1'b1; fim_jogo = 1'b0;
        ciclos = 0;
        while (!(m_rod == 255 && m_fase == 9) && ciclos < 8000) begin
            ciclo(1'b0);
            ciclos++;
        end
        chk("saturacao_atingida", int'(ciclos < 8000), 1);
        for (int i = 0; i < 40; i++) ciclo(1'b0);
        #1;
        chk("rodada_saturada", int'(rodada), 255);

        // Finish with a win at the tally and a restart from FIM.
        fim_jogo = 1'b1;
        for (int i = 0; i < 30; i++) ciclo(1'b0);
        fim_jogo = 1'b0;
        for (int i = 0; i < 5; i++) ciclo(1'b0);

        @(negedge clk);
        @(negedge clk);
        chk("fila_vazia", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
